// File: rtl/accel_pkg.sv
// Shared constants and types for the partial-sum output packer.
// Holds the packer state encoding, control-register bit positions and a frame-length helper.
package accel_pkg;

    localparam int BIT_WIDTH    = 8;
    localparam int NUM_KERNEL   = 4;
    localparam int REG_WIDTH    = 32;
    localparam int LANE_DEPTH   = 8;
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } packer_state_t;

    // A programmed frame length of zero still means a single word.
    function automatic logic [REG_WIDTH-1:0] last_word_index(input logic [REG_WIDTH-1:0] cnt);
        return (cnt == '0) ? '0 : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Synchronous first-word-fall-through lane FIFO with write bypass.
// A push into an empty FIFO is visible on dout/avail in the same cycle, so a value can be popped as it arrives.
module lane_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             avail,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             bypass;
    logic             do_write;
    logic             do_read;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // Value that arrives and leaves in the same cycle never touches the array.
    assign bypass   = empty && push && pop;
    assign do_write = push && (!full || pop) && !bypass;
    assign do_read  = pop && !empty;

    assign avail = !empty || push;
    assign dout  = empty ? din : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_read) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/psum_output_packer.sv
// Aligns four per-kernel psum lanes and packs them into {kn3,kn2,kn1,kn0} words on a valid/ready stream.
// Optional feature macro PSUM_RELU_EN: clamps negative (signed) lane values to zero at pack time.
module psum_output_packer #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int REG_WIDTH  = 32,
    parameter int LANE_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BIT_WIDTH-1:0]            i_psum_kn0,
    input  logic [BIT_WIDTH-1:0]            i_psum_kn1,
    input  logic [BIT_WIDTH-1:0]            i_psum_kn2,
    input  logic [BIT_WIDTH-1:0]            i_psum_kn3,
    input  logic                            i_psum_kn0_val,
    input  logic                            i_psum_kn1_val,
    input  logic                            i_psum_kn2_val,
    input  logic                            i_psum_kn3_val,
    output logic [BIT_WIDTH*NUM_KERNEL-1:0] o_data,
    output logic                            o_data_val,
    input  logic                            i_data_rdy,
    output logic                            o_data_last,
    output logic                            o_busy,
    output logic                            o_err_ovf,
    input  logic [REG_WIDTH-1:0]            i_conf_ctrl,
    input  logic [REG_WIDTH-1:0]            i_conf_cnt,
    input  logic [REG_WIDTH-1:0]            i_conf_knx
);

    import accel_pkg::*;

    localparam int WORD_WIDTH = BIT_WIDTH * NUM_KERNEL;

    packer_state_t state_reg;
    packer_state_t state_next;

    logic [REG_WIDTH-1:0]  last_idx_reg;
    logic [REG_WIDTH-1:0]  word_cnt_reg;
    logic [NUM_KERNEL-1:0] knx_reg;
    logic [WORD_WIDTH-1:0] data_reg;
    logic                  val_reg;
    logic                  err_reg;

    logic [BIT_WIDTH-1:0]  psum_in   [NUM_KERNEL];
    logic [BIT_WIDTH-1:0]  lane_dout [NUM_KERNEL];
    logic [BIT_WIDTH-1:0]  lane_val  [NUM_KERNEL];
    logic [NUM_KERNEL-1:0] psum_in_val;
    logic [NUM_KERNEL-1:0] lane_push;
    logic [NUM_KERNEL-1:0] lane_pop;
    logic [NUM_KERNEL-1:0] lane_avail;
    logic [NUM_KERNEL-1:0] lane_full;
    logic [NUM_KERNEL-1:0] lane_empty;
    logic [NUM_KERNEL-1:0] lane_ok;
    logic [NUM_KERNEL-1:0] lane_ovf;
    logic [WORD_WIDTH-1:0] packed_word;

    logic ctrl_en;
    logic ctrl_clr;
    logic running;
    logic abort;
    logic flush;
    logic handshake;
    logic is_last;
    logic pack;
    logic unused_conf;

    assign psum_in[0] = i_psum_kn0;
    assign psum_in[1] = i_psum_kn1;
    assign psum_in[2] = i_psum_kn2;
    assign psum_in[3] = i_psum_kn3;
    assign psum_in_val = {i_psum_kn3_val, i_psum_kn2_val, i_psum_kn1_val, i_psum_kn0_val};

    assign ctrl_en     = i_conf_ctrl[CTRL_EN_BIT];
    assign ctrl_clr    = i_conf_ctrl[CTRL_CLR_BIT];
    assign unused_conf = ^{i_conf_ctrl[REG_WIDTH-1:2], i_conf_knx[REG_WIDTH-1:NUM_KERNEL]};

    assign running   = (state_reg == RUN) && ctrl_en;
    assign abort     = (state_reg == RUN) && !ctrl_en;
    // Lanes only hold data while a frame is running; anything left over is discarded.
    assign flush     = (state_reg != RUN) || !ctrl_en;
    assign handshake = val_reg && i_data_rdy;
    assign is_last   = val_reg && (word_cnt_reg == last_idx_reg);

    // The final word must not be chased by another one, or it would be stranded in DONE.
    assign pack = running && (knx_reg != '0) && (&lane_ok) &&
                  (!val_reg || (i_data_rdy && !is_last));

    generate
        for (genvar gi = 0; gi < NUM_KERNEL; gi++) begin : g_lane
            assign lane_push[gi] = running && knx_reg[gi] && psum_in_val[gi];
            assign lane_pop[gi]  = pack && knx_reg[gi];
            assign lane_ok[gi]   = !knx_reg[gi] || lane_avail[gi];
            assign lane_ovf[gi]  = lane_push[gi] && lane_full[gi] && !lane_pop[gi];

`ifdef PSUM_RELU_EN
            assign lane_val[gi] = lane_dout[gi][BIT_WIDTH-1] ? '0 : lane_dout[gi];
`else
            assign lane_val[gi] = lane_dout[gi];
`endif

            assign packed_word[gi*BIT_WIDTH +: BIT_WIDTH] = knx_reg[gi] ? lane_val[gi] : '0;

            lane_fifo #(
                .WIDTH (BIT_WIDTH),
                .DEPTH (LANE_DEPTH)
            ) u_lane_fifo (
                .clk   (clk),
                .srst  (rst),
                .flush (flush),
                .push  (lane_push[gi]),
                .din   (psum_in[gi]),
                .pop   (lane_pop[gi]),
                .dout  (lane_dout[gi]),
                .avail (lane_avail[gi]),
                .full  (lane_full[gi]),
                .empty (lane_empty[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ctrl_en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!ctrl_en) begin
                    state_next = IDLE;
                end else if (handshake && is_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!ctrl_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx_reg <= '0;
            knx_reg      <= '0;
        end else if ((state_reg == IDLE) && ctrl_en) begin
            last_idx_reg <= last_word_index(i_conf_cnt);
            knx_reg      <= i_conf_knx[NUM_KERNEL-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            data_reg <= '0;
            val_reg  <= 1'b0;
        end else if (pack) begin
            data_reg <= packed_word;
            val_reg  <= 1'b1;
        end else if (handshake) begin
            val_reg  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort || (state_reg == IDLE)) begin
            word_cnt_reg <= '0;
        end else if (handshake) begin
            word_cnt_reg <= is_last ? '0 : word_cnt_reg + 1'b1;
        end
    end

    // Clear wins over an overflow reported in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || ctrl_clr) begin
            err_reg <= 1'b0;
        end else if (|lane_ovf) begin
            err_reg <= 1'b1;
        end
    end

    assign o_data      = data_reg;
    assign o_data_val  = val_reg;
    assign o_data_last = is_last;
    assign o_busy      = (state_reg != IDLE);
    assign o_err_ovf   = err_reg;

endmodule

// File: tb/tb_psum_output_packer.sv
// Self-checking bench for psum_output_packer: vector table, hand-written corner sequences, randomized scoreboard.
module tb_psum_output_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  kn [4];
    logic        kv [4];
    logic        rdy;
    logic [31:0] ctrl;
    logic [31:0] cnt;
    logic [31:0] knx;
    logic [31:0] o_data;
    logic        o_val;
    logic        o_last;
    logic        o_busy;
    logic        o_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  knx;
        logic [31:0] vals;
        logic [31:0] exp;
    } vec_t;

    vec_t       tbl [6];
    logic [7:0] lq  [4][$];

    always #5 clk = ~clk;

    psum_output_packer dut (
        .clk            (clk),
        .rst            (rst),
        .i_psum_kn0     (kn[0]),
        .i_psum_kn1     (kn[1]),
        .i_psum_kn2     (kn[2]),
        .i_psum_kn3     (kn[3]),
        .i_psum_kn0_val (kv[0]),
        .i_psum_kn1_val (kv[1]),
        .i_psum_kn2_val (kv[2]),
        .i_psum_kn3_val (kv[3]),
        .o_data         (o_data),
        .o_data_val     (o_val),
        .i_data_rdy     (rdy),
        .o_data_last    (o_last),
        .o_busy         (o_busy),
        .o_err_ovf      (o_err),
        .i_conf_ctrl    (ctrl),
        .i_conf_cnt     (cnt),
        .i_conf_knx     (knx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_push();
        for (int l = 0; l < 4; l++) kv[l] = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] c, input logic [3:0] m);
        cnt  = c;
        knx  = {28'h0, m};
        ctrl = 32'h1;
        tick();
    endtask

    task automatic stop_frame();
        ctrl = 32'h0;
        no_push();
        tick();
    endtask

    function automatic logic [7:0] relu(input logic [7:0] b);
`ifdef PSUM_RELU_EN
        return b[7] ? 8'h00 : b;
`else
        return b;
`endif
    endfunction

    function automatic logic [31:0] word_of(input int s);
        logic [31:0] w;
        for (int l = 0; l < 4; l++) w[l*8 +: 8] = 8'(s * 8 + l);
        return w;
    endfunction

    initial begin
        tbl[0] = '{4'hF, 32'h0403_0201, 32'h0403_0201};
        tbl[1] = '{4'h5, 32'hBB22_AA11, 32'h0022_0011};
        tbl[2] = '{4'hA, 32'h4433_2211, 32'h4400_2200};
        tbl[3] = '{4'h1, 32'h5555_557F, 32'h0000_007F};
`ifdef PSUM_RELU_EN
        tbl[4] = '{4'h3, 32'hBBCC_7F80, 32'h0000_7F00};
        tbl[5] = '{4'hC, 32'h6D9C_5B5A, 32'h6D00_0000};
`else
        tbl[4] = '{4'h3, 32'hBBCC_7F80, 32'h0000_7F80};
        tbl[5] = '{4'hC, 32'h6D9C_5B5A, 32'h6D9C_0000};
`endif

        rst  = 1'b1;
        rdy  = 1'b0;
        ctrl = 32'h0;
        cnt  = 32'h0;
        knx  = 32'h0;
        for (int l = 0; l < 4; l++) begin
            kn[l] = 8'h00;
            kv[l] = 1'b0;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_data", o_data, 32'h0);
        chk("reset_val", {31'h0, o_val}, 32'h0);
        chk("reset_last", {31'h0, o_last}, 32'h0);
        chk("reset_busy", {31'h0, o_busy}, 32'h0);
        chk("reset_err", {31'h0, o_err}, 32'h0);
        $display("reset state checked");

        // Three aligned words, one frame of cnt=3.
        start_frame(32'd3, 4'hF);
        chk("t1_busy", {31'h0, o_busy}, 32'h1);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int l = 0; l < 4; l++) begin
                kn[l] = 8'(l + 1);
                kv[l] = (i < 3);
            end
            chk("t1_val", {31'h0, o_val}, {31'h0, (i != 0)});
            if (i != 0) begin
                chk("t1_data", o_data, 32'h0403_0201);
                chk("t1_last", {31'h0, o_last}, {31'h0, (i == 3)});
            end
            tick();
        end
        no_push();
        chk("t1_done_val", {31'h0, o_val}, 32'h0);
        chk("t1_done_busy", {31'h0, o_busy}, 32'h1);
        stop_frame();
        chk("t1_idle", {31'h0, o_busy}, 32'h0);
        $display("seq aligned frame of 3 words");

        // Skewed lane arrival.
        start_frame(32'd1, 4'hF);
        for (int c = 0; c <= 6; c++) begin
            kn[0] = 8'h10; kn[1] = 8'h20; kn[2] = 8'h30; kn[3] = 8'h40;
            kv[0] = (c == 0);
            kv[1] = (c == 2);
            kv[2] = (c == 2);
            kv[3] = (c == 5);
            chk("t2_val", {31'h0, o_val}, {31'h0, (c == 6)});
            if (c == 6) begin
                chk("t2_data", o_data, 32'h4030_2010);
                chk("t2_last", {31'h0, o_last}, 32'h1);
            end
            tick();
        end
        chk("t2_drained", {31'h0, o_val}, 32'h0);
        stop_frame();
        $display("seq skewed lanes");

        // Backpressure, overflow and error clear.
        start_frame(32'd100, 4'hF);
        rdy = 1'b0;
        for (int s = 1; s <= 10; s++) begin
            for (int l = 0; l < 4; l++) begin
                kn[l] = 8'(s * 8 + l);
                kv[l] = 1'b1;
            end
            tick();
            no_push();
            chk("t3_hold_val", {31'h0, o_val}, 32'h1);
            chk("t3_hold_data", o_data, word_of(1));
            chk("t3_ovf", {31'h0, o_err}, {31'h0, (s == 10)});
        end
        ctrl = 32'h3;
        tick();
        chk("t3_clear", {31'h0, o_err}, 32'h0);
        ctrl = 32'h1;
        rdy  = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            chk("t3_drain_val", {31'h0, o_val}, 32'h1);
            chk("t3_drain_data", o_data, word_of(k));
            tick();
        end
        chk("t3_empty", {31'h0, o_val}, 32'h0);
        stop_frame();
        $display("seq backpressure and overflow");

        // Disabled lanes ignore their valid strobes.
        start_frame(32'd1, 4'h5);
        for (int i = 0; i < 12; i++) begin
            kn[1] = 8'($urandom);
            kn[3] = 8'($urandom);
            kv[1] = 1'b1;
            kv[3] = 1'b1;
            tick();
        end
        no_push();
        chk("t4_no_word", {31'h0, o_val}, 32'h0);
        chk("t4_no_ovf", {31'h0, o_err}, 32'h0);
        stop_frame();
        $display("seq disabled lane pulses");

        for (int v = 0; v < 6; v++) begin
            start_frame(32'd1, tbl[v].knx);
            rdy = 1'b1;
            for (int l = 0; l < 4; l++) begin
                kn[l] = tbl[v].vals[l*8 +: 8];
                kv[l] = 1'b1;
            end
            tick();
            no_push();
            chk("vec_val", {31'h0, o_val}, 32'h1);
            chk("vec_data", o_data, tbl[v].exp);
            chk("vec_last", {31'h0, o_last}, 32'h1);
            tick();
            chk("vec_done", {31'h0, o_val}, 32'h0);
            stop_frame();
            $display("vector %0d knx=%h vals=%h data=%h", v, tbl[v].knx, tbl[v].vals, o_data);
        end

        // Abort mid-frame, then a fresh frame.
        start_frame(32'd5, 4'hF);
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int l = 0; l < 4; l++) begin
                kn[l] = 8'(8'h01 + i);
                kv[l] = 1'b1;
            end
            tick();
        end
        rdy = 1'b0;
        for (int l = 0; l < 4; l++) kv[l] = (l != 3);
        tick();
        stop_frame();
        chk("t5_busy", {31'h0, o_busy}, 32'h0);
        chk("t5_val", {31'h0, o_val}, 32'h0);
        chk("t5_data", o_data, 32'h0);
        start_frame(32'd2, 4'hF);
        kn[3] = 8'h99;
        kv[3] = 1'b1;
        tick();
        no_push();
        chk("t5_flushed", {31'h0, o_val}, 32'h0);
        kn[0] = 8'h11; kn[1] = 8'h22; kn[2] = 8'h33;
        kv[0] = 1'b1;  kv[1] = 1'b1;  kv[2] = 1'b1;
        tick();
        no_push();
        chk("t5_word0", o_data, 32'h9933_2211);
        chk("t5_word0_last", {31'h0, o_last}, 32'h0);
        rdy = 1'b1;
        for (int l = 0; l < 4; l++) begin
            kn[l] = 8'h44;
            kv[l] = 1'b1;
        end
        tick();
        no_push();
        chk("t5_word1", o_data, 32'h4444_4444);
        chk("t5_word1_last", {31'h0, o_last}, 32'h1);
        tick();
        stop_frame();
        $display("seq abort and restart");

        // Randomized lanes and ready against a queue-based scoreboard.
        begin
            int         n_words;
            int         seen;
            int         pushed [4];
            int         budget;
            logic [3:0] m;
            logic [31:0] exp_w;
            logic        missing;
            n_words = 30;
            seen    = 0;
            budget  = 0;
            m       = 4'($urandom_range(1, 15));
            for (int l = 0; l < 4; l++) pushed[l] = 0;
            start_frame(n_words, m);
            while (budget < 4000 && seen < n_words) begin
                rdy = ($urandom_range(0, 2) != 0);
                for (int l = 0; l < 4; l++) begin
                    kn[l] = 8'($urandom);
                    if (m[l]) begin
                        kv[l] = (pushed[l] < n_words) && (pushed[l] - seen < 8) &&
                                ($urandom_range(0, 1) == 1);
                        if (kv[l]) begin
                            lq[l].push_back(kn[l]);
                            pushed[l]++;
                        end
                    end else begin
                        kv[l] = ($urandom_range(0, 1) == 1);
                    end
                end
                if (o_val && rdy) begin
                    exp_w   = 32'h0;
                    missing = 1'b0;
                    for (int l = 0; l < 4; l++) begin
                        if (m[l]) begin
                            if (lq[l].size() == 0) missing = 1'b1;
                            else exp_w[l*8 +: 8] = relu(lq[l].pop_front());
                        end
                    end
                    chk("rand_unexpected_word", {31'h0, missing}, 32'h0);
                    chk("rand_data", o_data, exp_w);
                    chk("rand_last", {31'h0, o_last}, {31'h0, (seen == n_words - 1)});
                    $display("rand word %0d data=%h last=%0b", seen, o_data, o_last);
                    seen++;
                end
                tick();
                budget++;
            end
            no_push();
            chk("rand_word_count", seen, n_words);
            chk("rand_err", {31'h0, o_err}, 32'h0);
            chk("rand_done", {31'h0, o_busy}, 32'h1);
            stop_frame();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
